periph_irq_ctrl: RTL
====================

Name: periph_irq_ctrl

Overview:
Interrupt controller that collects the flag/enable pairs exported by the peripheral SFRs (timer ovf_f/match0_f/match1_f, PWM prm_f/dcm_f/phm_f/ofm_f) and presents one interrupt at a time to the RISC-V core.
- Latches an enabled flag's rising edge into a pending register.
- Arbitrates by fixed priority.
- Runs a request/acknowledge/end-of-interrupt handshake with the core trap logic.
- Sits between the peripheral SFR blocks and the core.

Parameters:
- N_SRC, 8, number of interrupt sources; index 0 has the highest priority.
- ID_W, $clog2(N_SRC), width of the interrupt ID.

Ports:
- sys_clk  in  1  system clock; all state is updated on its rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- sw_rst_i  in  1  chip_ctrl.sw_rst; synchronous clear of all state.
- glb_en_i  in  1  global interrupt enable from core (mstatus.MIE).
- src_flag_i  in  N_SRC  peripheral flag bits (level, software-cleared in the SFR).
- src_en_i  in  N_SRC  matching enable bits from the SFRs.
- irq_req_o  out  1  interrupt request to core.
- irq_id_o  out  ID_W  ID of the requested or serviced source.
- irq_ack_i  in  1  one-cycle pulse: core has taken the trap.
- irq_eoi_i  in  1  one-cycle pulse: ISR finished (mret).
- pend_o  out  N_SRC  pending register, readable via SFR.
- busy_o  out  1  high in the SERVICE state.
- lost_o  out  1  sticky flag: an edge arrived while that source was already pending or in service.
- lost_clr_i  in  1  clears lost_o.

Behaviour:
- Reset (sys_rst_n low, asynchronous): state=IDLE; flag_q, pend, irq_req_o, irq_id_o, busy_o, lost_o all 0. sw_rst_i high produces the same values synchronously and has priority over every other input.
- Edge detect: flag_q <= src_flag_i every cycle. edge[i] = src_flag_i[i] & ~flag_q[i] & src_en_i[i].
- Enable gating: an edge with src_en_i low is discarded and never becomes pending later. Dropping src_en_i while a bit is pending does not clear that bit.
- Pending set: pend[i] <= 1 on edge[i]. The bit is visible on pend_o in the cycle after the flag rises.
- Lost event: if edge[i] arrives while pend[i]=1 or source i is in service, set lost_o <= 1. lost_clr_i clears lost_o; if a lost event and lost_clr_i occur in the same cycle, set wins.
- Arbitration (combinational): sel = lowest index with pend=1; any = |pend.
- IDLE:
  - if any & glb_en_i: irq_req_o<=1, irq_id_o<=sel, go to REQ. irq_req_o therefore rises 2 cycles after the flag rises.
- REQ:
  - irq_req_o held high and irq_id_o held stable (no re-arbitration, even if a higher-priority source becomes pending).
  - glb_en_i low: irq_req_o<=0, go to IDLE; the pend bit is kept.
  - irq_ack_i: irq_req_o<=0, pend[irq_id_o]<=0, busy_o<=1, go to SERVICE. irq_id_o holds the serviced ID.
  - If irq_ack_i and edge on the same source coincide, the pend clear wins and the edge counts as lost.
  - If irq_ack_i and glb_en_i low coincide, the ack wins.
- SERVICE:
  - No nesting; new edges still set pend.
  - irq_eoi_i: busy_o<=0, go to IDLE. The next request can be raised on the following cycle, so at least 1 idle cycle separates EOI from the next irq_req_o.
- Stray handshakes: irq_ack_i outside REQ and irq_eoi_i outside SERVICE are ignored with no state change.
- irq_id_o holds its last value in IDLE.
- Illegal state encoding: recover to IDLE.

Decomposition:
- pkg_sfrs_definition receives:
  - irq_state_t enum (IDLE, REQ, SERVICE).
  - Source index localparams: IRQ_TMR_OVF=0, IRQ_TMR_M0=1, IRQ_TMR_M1=2, IRQ_PWM_PRM=3, IRQ_PWM_DCM=4, IRQ_PWM_PHM=5, IRQ_PWM_OFM=6, IRQ_SPARE=7.
- One sub-module, irq_prio_enc: parameterised N_SRC-to-ID_W lowest-index priority encoder with a valid output.

Test Plan:
- Single source: glb_en=1, en[2]=1, flag[2] rises at cycle 10 -> pend_o=8'h04 at cycle 11, irq_req_o=1 with id=2 at cycle 12. Ack at cycle 15 -> req=0, pend_o=0, busy=1. EOI at cycle 20 -> busy=0.
- Priority: flags 5 and 1 rise in the same cycle -> id=1 served first. After its EOI, id=5 requested 1 cycle later.
- Locked request: in REQ with id=4, flag 0 rises -> id stays 4 until ack. After EOI, next request has id=0.
- Gating: en[3]=0 and flag[3] rises -> pend stays 0. glb_en=0 with pend[1]=1 -> no req. glb_en dropped while in REQ -> req withdrawn, pend[1] still 1.
- Lost: flag[6] pulses twice while pend[6]=1 -> lost_o=1. lost_clr_i -> lost_o=0.
- Reset: sw_rst_i pulsed in SERVICE with pend=8'h0A -> next cycle all outputs 0, state IDLE. sys_rst_n asserted mid-REQ -> irq_req_o drops immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pkg_sfrs_definition.sv
// Shared SFR-side definitions for the peripheral interrupt controller:
// controller state encoding and the interrupt source index map.
package pkg_sfrs_definition;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;

  localparam int unsigned IRQ_TMR_OVF = 32'd0;
  localparam int unsigned IRQ_TMR_M0  = 32'd1;
  localparam int unsigned IRQ_TMR_M1  = 32'd2;
  localparam int unsigned IRQ_PWM_PRM = 32'd3;
  localparam int unsigned IRQ_PWM_DCM = 32'd4;
  localparam int unsigned IRQ_PWM_PHM = 32'd5;
  localparam int unsigned IRQ_PWM_OFM = 32'd6;
  localparam int unsigned IRQ_SPARE   = 32'd7;

endpackage

// File: rtl/periph_irq_ctrl_prio_enc.sv
// Lowest-index-wins priority encoder: index 0 carries the highest priority.
module irq_prio_enc #(
  parameter int N_SRC = 8,
  parameter int ID_W  = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  output logic [ID_W-1:0]  sel,
  output logic             valid
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    sel   = {ID_W{1'b0}};
    valid = |req;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        sel = ID_W'(i);
      end else begin
        sel = sel;
      end
    end
  end

endmodule

// File: rtl/periph_irq_ctrl.sv
// Peripheral interrupt controller: latches enabled flag edges into a pending
// register and presents one fixed-priority request at a time to the core.
module periph_irq_ctrl
  import pkg_sfrs_definition::*;
#(
  parameter int N_SRC = 8,
  parameter int ID_W  = $clog2(N_SRC)
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             sw_rst_i,
  input  logic             glb_en_i,
  input  logic [N_SRC-1:0] src_flag_i,
  input  logic [N_SRC-1:0] src_en_i,
  output logic             irq_req_o,
  output logic [ID_W-1:0]  irq_id_o,
  input  logic             irq_ack_i,
  input  logic             irq_eoi_i,
  output logic [N_SRC-1:0] pend_o,
  output logic             busy_o,
  output logic             lost_o,
  input  logic             lost_clr_i
);

  irq_state_t       state_r;
  logic [N_SRC-1:0] flag_r;
  logic [N_SRC-1:0] pend_r;
  logic             req_r;
  logic [ID_W-1:0]  id_r;
  logic             busy_r;
  logic             lost_r;

  logic [N_SRC-1:0] edge_s;
  logic [N_SRC-1:0] svc_mask_s;
  logic [N_SRC-1:0] ack_mask_s;
  logic [N_SRC-1:0] pend_nxt_s;
  logic             take_s;
  logic             lost_evt_s;
  logic [ID_W-1:0]  sel_s;
  logic             any_s;

  irq_prio_enc #(
    .N_SRC (N_SRC),
    .ID_W  (ID_W)
  ) u_prio (
    .req   (pend_r),
    .sel   (sel_s),
    .valid (any_s)
  );

  // Edge detection, pending next-state and lost-event detection.
  always_comb begin
    edge_s     = src_flag_i & ~flag_r & src_en_i;
    take_s     = (state_r == REQ) && irq_ack_i;
    svc_mask_s = {N_SRC{1'b0}};
    ack_mask_s = {N_SRC{1'b0}};
    if (state_r == SERVICE) begin
      svc_mask_s[id_r] = 1'b1;
    end else begin
      svc_mask_s = {N_SRC{1'b0}};
    end
    if (take_s) begin
      ack_mask_s[id_r] = 1'b1;
    end else begin
      ack_mask_s = {N_SRC{1'b0}};
    end
    // An ack clears the bit even if the same source re-fires; that edge is lost.
    lost_evt_s = |(edge_s & (pend_r | svc_mask_s));
    pend_nxt_s = (pend_r | edge_s) & ~ack_mask_s;
  end

  // Flag history, pending register and sticky lost flag.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      flag_r <= {N_SRC{1'b0}};
      pend_r <= {N_SRC{1'b0}};
      lost_r <= 1'b0;
    end else if (sw_rst_i) begin
      flag_r <= {N_SRC{1'b0}};
      pend_r <= {N_SRC{1'b0}};
      lost_r <= 1'b0;
    end else begin
      flag_r <= src_flag_i;
      pend_r <= pend_nxt_s;
      if (lost_evt_s) begin
        lost_r <= 1'b1;
      end else if (lost_clr_i) begin
        lost_r <= 1'b0;
      end else begin
        lost_r <= lost_r;
      end
    end
  end

  // Request / acknowledge / end-of-interrupt handshake with registered outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r <= IDLE;
      req_r   <= 1'b0;
      id_r    <= {ID_W{1'b0}};
      busy_r  <= 1'b0;
    end else if (sw_rst_i) begin
      state_r <= IDLE;
      req_r   <= 1'b0;
      id_r    <= {ID_W{1'b0}};
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (any_s && glb_en_i) begin
            req_r   <= 1'b1;
            id_r    <= sel_s;
            state_r <= REQ;
          end
        end
        REQ: begin
          // ID is frozen here: a newly pending higher-priority source waits.
          if (irq_ack_i) begin
            req_r   <= 1'b0;
            busy_r  <= 1'b1;
            state_r <= SERVICE;
          end else if (!glb_en_i) begin
            req_r   <= 1'b0;
            state_r <= IDLE;
          end
        end
        SERVICE: begin
          if (irq_eoi_i) begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          req_r   <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign irq_req_o = req_r;
  assign irq_id_o  = id_r;
  assign pend_o    = pend_r;
  assign busy_o    = busy_r;
  assign lost_o    = lost_r;

endmodule
